// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single shared memory port.
// Round-robin on conflict, per-transaction wait counter with timeout reporting.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sign_mask,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sign_mask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;
  typedef enum logic {GNT_IF, GNT_D} grant_t;

  // Counter value seen on the TIMEOUT-th BUSY cycle without an ack.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  grant_t      last_q, last_d;
  logic [7:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_req;

  assign d_req = d_rd | d_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= GNT_IF;
      wait_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wait_d     = wait_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready   = 1'b0;
    d_ready    = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On conflict the port that did not win last time goes first.
        if (if_req && (!d_req || last_q == GNT_D)) begin
          state_d = IF_BUSY;
          last_d  = GNT_IF;
          wait_d  = '0;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          mask_d  = 4'b0010;
        end else if (d_req) begin
          state_d = D_BUSY;
          last_d  = GNT_D;
          wait_d  = '0;
          we_d    = d_wr;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          mask_d  = d_sign_mask;
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          if_ready   = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = IDLE;
        end else if (wait_q == LIMIT) begin
          if_ready   = 1'b1;
          err        = 1'b1;
          if_rdata_d = '0;
          state_d    = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          d_ready   = 1'b1;
          d_rdata_d = mem_rdata;
          state_d   = IDLE;
        end else if (wait_q == LIMIT) begin
          d_ready   = 1'b1;
          err       = 1'b1;
          d_rdata_d = '0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data passes through in the completion cycle, otherwise holds.
  assign if_rdata      = if_rdata_d;
  assign d_rdata       = d_rdata_d;
  assign mem_req       = (state_q != IDLE);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_sign_mask = mask_q;
  assign stall         = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_rd, d_wr, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_sign_mask;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, stall, err;
  logic [3:0]  mem_sign_mask;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_lat = 0;
  int   busy_cnt = 0;
  int   cyc;
  int   nready;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sign_mask(d_sign_mask), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sign_mask(mem_sign_mask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : a + 32'h1000;
  endfunction

  function automatic exp_t mk(input bit is_d, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [3:0] mask,
                              input logic [31:0] rdata, input logic e);
    exp_t x;
    x.is_d = is_d; x.addr = addr; x.we = we; x.wdata = wdata;
    x.mask = mask; x.rdata = rdata; x.err = e;
    return x;
  endfunction

  // Memory model: acks on BUSY cycle index ack_lat (0 = first cycle).
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (busy_cnt == ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = rfn(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 32'hDEADBEEF;
        end
        busy_cnt++;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        busy_cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {30'b0, if_ready, d_ready}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("ready_port", {30'b0, if_ready, d_ready}, mon_e.is_d ? 32'h1 : 32'h2);
          check("mem_addr", mem_addr, mon_e.addr);
          check("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          check("mem_wdata", mem_wdata, mon_e.wdata);
          check("mem_sign_mask", {28'b0, mem_sign_mask}, {28'b0, mon_e.mask});
          check("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
          check("err", {31'b0, err}, {31'b0, mon_e.err});
        end
      end else if (err) begin
        check("stray_err", {31'b0, err}, 32'h0);
      end
    end
  end

  task automatic wait_ready(input bit is_d, output int cycles);
    bit found = 0;
    cycles = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req) cycles++;
      if (is_d ? d_ready : if_ready) found = 1;
    end
    if (!found) check("ready_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 0; d_rd = 0; d_wr = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_sign_mask = '0;
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_outs", {if_ready, d_ready, err, mem_we, mem_sign_mask}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_rdata", if_rdata | d_rdata | mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Fetch, ack on 4th BUSY cycle
    ack_lat = 3;
    @(posedge clk); #2;
    if_req = 1; if_addr = 32'h100;
    sb.push_back(mk(0, 32'h100, 0, 32'h0, 4'b0010, 32'h13, 0));
    @(negedge clk);
    check("fetch_stall_req", {31'b0, stall}, 32'h1);
    check("fetch_req_cycle_memreq", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    check("fetch_memreq_next", {31'b0, mem_req}, 32'h1);
    wait_ready(0, cyc);
    check("fetch_busy_cycles", cyc, 32'd3);
    @(posedge clk); #2 if_req = 0;
    @(negedge clk);
    check("fetch_stall_after", {31'b0, stall}, 32'h0);
    check("fetch_rdata_hold", if_rdata, 32'h13);
    check("fetch_memreq_after", {31'b0, mem_req}, 32'h0);

    // Write, immediate ack: ready in the cycle after the request
    ack_lat = 0;
    @(posedge clk); #2;
    d_wr = 1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_sign_mask = 4'b0010;
    sb.push_back(mk(1, 32'h2000, 1, 32'hCAFEF00D, 4'b0010, 32'h3000, 0));
    wait_ready(1, cyc);
    check("write_latency", cyc, 32'd1);
    @(posedge clk); #2 d_wr = 0;
    @(negedge clk);
    check("write_rdata_hold", d_rdata, 32'h3000);

    // Read and write together act as a write
    ack_lat = 2;
    @(posedge clk); #2;
    d_rd = 1; d_wr = 1; d_addr = 32'h3000; d_wdata = 32'h11112222; d_sign_mask = 4'b0001;
    sb.push_back(mk(1, 32'h3000, 1, 32'h11112222, 4'b0001, 32'h4000, 0));
    wait_ready(1, cyc);
    @(posedge clk); #2 d_rd = 0; d_wr = 0; d_wdata = '0;

    // Reset, then continuous conflict: D, IF, D, IF
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    ack_lat = 1;
    @(posedge clk); #2;
    if_req = 1; if_addr = 32'h600;
    d_rd = 1; d_addr = 32'h500; d_sign_mask = 4'b0100;
    sb.push_back(mk(1, 32'h500, 0, 32'h0, 4'b0100, 32'h1500, 0));
    sb.push_back(mk(0, 32'h600, 0, 32'h0, 4'b0010, 32'h1600, 0));
    sb.push_back(mk(1, 32'h500, 0, 32'h0, 4'b0100, 32'h1500, 0));
    sb.push_back(mk(0, 32'h600, 0, 32'h0, 4'b0010, 32'h1600, 0));
    nready = 0;
    for (int i = 0; i < 60 && nready < 4; i++) begin
      @(negedge clk);
      check("conflict_stall", {31'b0, stall}, 32'h1);
      if (if_ready || d_ready) nready++;
    end
    check("conflict_count", nready, 32'd4);
    @(posedge clk); #2 if_req = 0; d_rd = 0;

    // Timeout with no ack: err on 4th BUSY cycle
    ack_lat = 100;
    @(posedge clk); #2;
    d_rd = 1; d_addr = 32'h40; d_sign_mask = 4'b0001;
    sb.push_back(mk(1, 32'h40, 0, 32'h0, 4'b0001, 32'h0, 1));
    wait_ready(1, cyc);
    check("timeout_cycles", cyc, 32'd4);
    @(posedge clk); #2 d_rd = 0;
    @(negedge clk);
    check("timeout_memreq_after", {31'b0, mem_req}, 32'h0);
    check("timeout_rdata_hold", d_rdata, 32'h0);

    // Reset mid-BUSY, then re-grant of held fetch
    @(posedge clk); #2;
    if_req = 1; if_addr = 32'h700;
    repeat (2) @(negedge clk);
    check("midbusy_memreq", {31'b0, mem_req}, 32'h1);
    @(posedge clk); #3 rst_n = 0;
    #1;
    check("async_rst_memreq", {31'b0, mem_req}, 32'h0);
    check("async_rst_ready", {30'b0, if_ready, d_ready}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    ack_lat = 0;
    sb.push_back(mk(0, 32'h700, 0, 32'h0, 4'b0010, 32'h1700, 0));
    rst_n = 1;
    wait_ready(0, cyc);
    check("regrant_latency", cyc, 32'd1);
    @(posedge clk); #2 if_req = 0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum BUSY cycles to wait for mem_ack (range 1-255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetch data.
REQ-007 if_ready  out  1  fetch completion, one-cycle pulse.
REQ-008 d_rd  in  1  data read request; held high until d_ready.
REQ-009 d_wr  in  1  data write request; held high until d_ready.
REQ-010 d_addr  in  32  data byte address.
REQ-011 d_wdata  in  32  write data.
REQ-012 d_sign_mask  in  4  data-memory sign/size mask.
REQ-013 d_rdata  out  32  data read result.
REQ-014 d_ready  out  1  data completion, one-cycle pulse.
REQ-015 mem_req  out  1  shared-port request.
REQ-016 mem_we  out  1  shared-port write enable.
REQ-017 mem_addr  out  32  shared-port address.
REQ-018 mem_wdata  out  32  shared-port write data.
REQ-019 mem_sign_mask  out  4  shared-port sign/size mask; 4'b0010 (word) for fetches.
REQ-020 mem_ack  in  1  shared-port completion; sampled only while mem_req=1.
REQ-021 mem_rdata  in  32  shared-port read data, valid in the mem_ack cycle.
REQ-022 stall  out  1  pipeline stall to CPU.
REQ-023 err  out  1  timeout indication, one-cycle pulse.

Function
REQ-024 The FSM SHALL have states IDLE, IF_BUSY and D_BUSY.
REQ-025 In IDLE with exactly one port requesting, the block SHALL grant that port on the next edge.
REQ-026 In IDLE with both ports requesting, the block SHALL grant the port other than last_grant.
REQ-027 last_grant SHALL be a 1-bit register updated at every grant.
REQ-028 At each grant the block SHALL register mem_addr, mem_we, mem_wdata and mem_sign_mask from the granted port, and those outputs SHALL stay stable until the state leaves BUSY.
REQ-029 d_rd and d_wr both high SHALL be treated as a write (mem_we=1).
REQ-030 mem_req SHALL be 1 exactly while the state is IF_BUSY or D_BUSY.
REQ-031 In X_BUSY with mem_ack=1, X_ready SHALL be 1 combinationally in that same cycle, X_rdata SHALL equal mem_rdata in that cycle, and the state SHALL return to IDLE at the next edge.
REQ-032 X_rdata SHALL hold the last completed value when X_ready=0.
REQ-033 Minimum latency SHALL be request cycle N, mem_req at N+1, ready at N+1 if mem_ack arrives immediately; IDLE turnaround is one cycle.
REQ-034 An 8-bit wait counter SHALL clear at each grant and increment on every BUSY cycle without mem_ack.
REQ-035 When the wait counter reaches TIMEOUT, the block SHALL pulse err and X_ready, force X_rdata to 32'h0 in that cycle, and return to IDLE.
REQ-036 Dropping a request mid-transaction SHALL NOT abort it; the transaction completes and ready still pulses.
REQ-037 A request seen in the cycle after a ready pulse SHALL be treated as a new request.
REQ-038 The block SHALL compute stall = (if_req & ~if_ready) | ((d_rd|d_wr) & ~d_ready), combinationally.

Reset
REQ-039 While rst_n=0 the block SHALL hold state=IDLE, last_grant=IF, wait counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_sign_mask=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0 and err=0, asynchronously.
REQ-040 Reset asserted mid-transaction SHALL drop mem_req immediately and issue no ready pulse.

Verification
REQ-041 Fetch case: if_req, if_addr=0x100, mem_ack 3 cycles after mem_req with mem_rdata=0x00000013 -> mem_addr=0x100, mem_we=0; if_ready pulses once in the ack cycle with if_rdata=0x13; stall=0 the cycle after.
REQ-042 Both ports request right after reset -> the D port is granted first, then IF; two ready pulses in that order; stall high throughout.
REQ-043 Continuous conflict over 4 transactions -> grants alternate D, IF, D, IF.
REQ-044 Write case: d_wr, d_addr=0x2000, d_wdata=0xCAFEF00D, d_sign_mask=4'b0010 -> mem_we=1 and the same values appear on mem_*; d_ready pulses on ack.
REQ-045 Timeout case: TIMEOUT=4, no mem_ack -> err and d_ready pulse on the 4th BUSY cycle with d_rdata=0; mem_req low the next cycle.
REQ-046 Reset mid-BUSY case: rst_n low mid-BUSY -> mem_req=0 without a clock edge; after release, a held if_req is re-granted normally.
